// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared owner/state types and defaults for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_LD   = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CORE = 2'd1,
        ST_LOCK = 2'd2
    } state_e;

    localparam int MAX_BURST_DEF = 8;

endpackage

// File: rtl/dmem_rd_return.sv
// rtl/dmem_rd_return.sv - steers 1-cycle-latency memory read data back to its requester
module dmem_rd_return
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  owner_e            issue_owner,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid
);

    logic              rd_pend;
    owner_e            rd_owner;
    logic [DATA_W-1:0] core_hold;
    logic [DATA_W-1:0] ld_hold;

    // Track the read issued last cycle and remember each side's last returned word
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend   <= 1'b0;
            rd_owner  <= OWN_CORE;
            core_hold <= '0;
            ld_hold   <= '0;
        end else begin
            rd_pend   <= issue;
            rd_owner  <= issue_owner;
            core_hold <= core_rdata;
            ld_hold   <= ld_rdata;
        end
    end

    // A return arriving while reset is asserted is dropped, not delivered
    always_comb begin
        core_rvalid = rd_pend && (rd_owner == OWN_CORE) && !rst;
        ld_rvalid   = rd_pend && (rd_owner == OWN_LD) && !rst;
        core_rdata  = core_rvalid ? mem_rdata : core_hold;
        ld_rdata    = ld_rvalid ? mem_rdata : ld_hold;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/loader data-memory arbiter with burst lock; optional ARB_PERF_CNT_EN counters
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_last,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              mem_writeEn,
    output logic              mem_readEn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_core_stall,
    output logic [31:0]       perf_ld_beats
`endif
);

    localparam int              CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    owner_e           last_owner_q, last_owner_d;
    logic             core_gnt;
    logic             lock_hold;

    // Arbitration state register; loader counts as last owner so the core wins the first tie
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            last_owner_q <= OWN_LD;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Same-cycle grant, memory command and next-state; the lock lapses once MAX_BURST beats are done
    always_comb begin
        core_gnt     = 1'b0;
        ld_gnt       = 1'b0;
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        last_owner_d = last_owner_q;
        mem_writeEn  = 1'b0;
        mem_readEn   = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        lock_hold    = (state_q == ST_LOCK) && (beat_cnt_q < BURST_LIM);

        if (!RST) begin
            if (lock_hold && ld_req) begin
                ld_gnt = 1'b1;
            end else if (core_req && ld_req) begin
                if (last_owner_q == OWN_CORE) begin
                    ld_gnt = 1'b1;
                end else begin
                    core_gnt = 1'b1;
                end
            end else if (core_req) begin
                core_gnt = 1'b1;
            end else if (ld_req) begin
                ld_gnt = 1'b1;
            end
        end

        if (core_gnt) begin
            state_d      = ST_CORE;
            beat_cnt_d   = '0;
            last_owner_d = OWN_CORE;
            mem_writeEn  = core_we;
            mem_readEn   = !core_we;
            mem_addr     = core_addr;
            mem_wdata    = core_wdata;
        end else if (ld_gnt) begin
            last_owner_d = OWN_LD;
            mem_writeEn  = ld_we;
            mem_readEn   = !ld_we;
            mem_addr     = ld_addr;
            mem_wdata    = ld_wdata;
            if (ld_last) begin
                state_d    = ST_IDLE;
                beat_cnt_d = '0;
            end else if (lock_hold) begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end else begin
                state_d    = ST_LOCK;
                beat_cnt_d = CNT_W'(1);
            end
        end else begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
        end

        core_stall = core_req && !core_gnt && !RST;
    end

    dmem_rd_return #(
        .DATA_W(DATA_W)
    ) u_rd_return (
        .clk        (CLK),
        .rst        (RST),
        .issue      ((core_gnt && !core_we) || (ld_gnt && !ld_we)),
        .issue_owner(ld_gnt ? OWN_LD : OWN_CORE),
        .mem_rdata  (mem_rdata),
        .core_rdata (core_rdata),
        .core_rvalid(core_rvalid),
        .ld_rdata   (ld_rdata),
        .ld_rvalid  (ld_rvalid)
    );

`ifdef ARB_PERF_CNT_EN
    // Saturating event counters for stalled core cycles and accepted loader beats
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_core_stall <= '0;
            perf_ld_beats   <= '0;
        end else begin
            if (core_stall && (perf_core_stall != '1)) begin
                perf_core_stall <= perf_core_stall + 32'd1;
            end
            if (ld_gnt && (perf_ld_beats != '1)) begin
                perf_ld_beats <= perf_ld_beats + 32'd1;
            end
        end
    end
`endif

endmodule
